// File: rtl/mult_wide_mac.sv
// mult_wide_mac
//   Fully pipelined signed wide multiply-accumulate. Each accepted beat
//   computes t = (a*b + c [+ 2^(SHIFT-1)]) >>> SHIFT and folds t into a
//   saturating PW-bit accumulator p. The sticky flag ovf records any
//   saturation.
//
//   The B operand is consumed in 17-bit slices, one pipeline stage per slice,
//   so that each stage matches one DSP48E1 multiplier (25x18 signed). The
//   lower slices are unsigned (zero-extended to 18 bits) and the top slice is
//   signed. a and b travel down the chain beside the running sum.
//
//   Latency is NB + 2 cycles, where NB = ceil(BW/17): stage 0 registers the
//   inputs, NB slice stages follow, then one shift/round stage, then the
//   output/accumulate stage.
//
//   Handshake: in_valid qualifies a, b, c and acc. There is no ready signal,
//   so every beat with in_valid=1 is consumed on that edge. out_valid pulses
//   for exactly one cycle per consumed beat, in order, and p and ovf change
//   only on those cycles (ovf_clear excepted).
//
// Ports
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   input beat qualifier
//   a [AW]     signed multiplicand
//   b [BW]     signed multiplier
//   c [CW]     signed addend, sign-extended
//   acc        0: start a new sum, 1: add to the current accumulator
//   ovf_clear  clears ovf on the next edge unless a saturation happens then
//   out_valid  p was updated this cycle
//   p [PW]     signed saturated accumulator
//   ovf        sticky saturation flag
module mult_wide_mac #(
  parameter int AW    = 25,
  parameter int BW    = 35,
  parameter int CW    = 48,
  parameter int PW    = 48,
  parameter int SHIFT = 17,
  parameter int ROUND = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [CW-1:0] c,
  input  logic                 acc,
  input  logic                 ovf_clear,
  output logic                 out_valid,
  output logic signed [PW-1:0] p,
  output logic                 ovf
);

  localparam int NB  = (BW + 16) / 17;           // number of 17-bit B slices
  localparam int XW  = NB * 17;                  // B padded to whole slices
  localparam int SW  = AW + BW + 1;              // full-precision sum width
  localparam int TW  = SW + 1;                   // room for the rounding add
  localparam int RW  = ((PW > TW) ? PW : TW) + 1; // accumulate width
  localparam int PPW = AW + 18;                  // one partial product
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [TW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (TW'(1) << RSH) : '0;
  localparam logic signed [RW-1:0] PMAX = {{(RW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [RW-1:0] PMIN = {{(RW-PW+1){1'b1}}, {(PW-1){1'b0}}};

  // Operand chain: element k feeds the multiplier of slice k.
  logic signed [AW-1:0]  a_q   [NB];
  logic signed [XW-1:0]  bx_q  [NB];
  logic signed [CW-1:0]  c_q;
  logic signed [SW-1:0]  sum_q [NB];  // sum_q[k] holds slices 0..k plus c
  logic signed [TW-1:0]  t_q;

  // Control chain: index k+1 travels beside sum_q[k].
  logic                  v_q   [NB+1];
  logic                  acc_q [NB+1];
  logic                  v_t;
  logic                  acc_t;

  logic signed [17:0]    sl    [NB];
  logic signed [PPW-1:0] prod  [NB];
  logic signed [SW-1:0]  term  [NB];
  logic signed [SW-1:0]  nsum  [NB];
  logic signed [TW-1:0]  rs;
  logic signed [TW-1:0]  tn;
  logic signed [RW-1:0]  r;
  logic                  sat;
  logic signed [PW-1:0]  pn;

  // Partial products and the running sum for every slice stage.
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) begin
        sl[k] = {bx_q[k][17*k+16], bx_q[k][17*k +: 17]};
      end else begin
        sl[k] = {1'b0, bx_q[k][17*k +: 17]};
      end
      prod[k] = PPW'(a_q[k]) * PPW'(sl[k]);
      // Wraparound modulo 2^SW is harmless: the completed sum always fits.
      term[k] = SW'(prod[k]) <<< (17 * k);
    end
    nsum[0] = SW'(c_q) + term[0];
    for (int k = 1; k < NB; k++) begin
      nsum[k] = sum_q[k-1] + term[k];
    end
  end

  // Rounding offset and arithmetic shift.
  always_comb begin
    rs = TW'(sum_q[NB-1]) + RND;
    tn = rs >>> SHIFT;
  end

  // Accumulate with saturation; the feedback from p stays inside this stage,
  // so back-to-back acc=1 beats need no forwarding.
  always_comb begin
    r   = (acc_t ? RW'(p) : '0) + RW'(t_q);
    sat = 1'b0;
    pn  = r[PW-1:0];
    if (r > PMAX) begin
      sat = 1'b1;
      pn  = PMAX[PW-1:0];
    end else if (r < PMIN) begin
      sat = 1'b1;
      pn  = PMIN[PW-1:0];
    end
  end

  // Datapath registers: qualified by the valid chain, so no reset needed.
  always_ff @(posedge clock) begin
    a_q[0]  <= a;
    bx_q[0] <= XW'(b);
    c_q     <= c;
    for (int k = 1; k < NB; k++) begin
      a_q[k]  <= a_q[k-1];
      bx_q[k] <= bx_q[k-1];
    end
    for (int k = 0; k < NB; k++) begin
      sum_q[k] <= nsum[k];
    end
    t_q <= tn;
  end

  // Control and architectural state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= NB; k++) begin
        v_q[k]   <= 1'b0;
        acc_q[k] <= 1'b0;
      end
      v_t       <= 1'b0;
      acc_t     <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
    end else begin
      v_q[0]   <= in_valid;
      acc_q[0] <= acc;
      for (int k = 1; k <= NB; k++) begin
        v_q[k]   <= v_q[k-1];
        acc_q[k] <= acc_q[k-1];
      end
      v_t       <= v_q[NB];
      acc_t     <= acc_q[NB];
      out_valid <= v_t;
      if (v_t) begin
        p <= pn;
      end
      // A saturation in the same cycle beats a clear request.
      if (v_t && sat) begin
        ovf <= 1'b1;
      end else if (ovf_clear) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_wide_mac.sv
// tb_mult_wide_mac
//   Self-checking bench for mult_wide_mac at default parameters, plus a
//   second instance built with ROUND=1 fed the same stimulus. The reference
//   model works in plain 64-bit integer arithmetic: every accepted beat is
//   booked with its due edge (issue edge + LAT) and its shifted term, and is
//   folded into the modelled accumulator when that edge arrives.
module tb_mult_wide_mac;

  localparam int     LAT  = 5;
  localparam longint PMAX = (64'sd1 <<< 47) - 1;
  localparam longint PMIN = -(64'sd1 <<< 47);
  localparam longint T41  = 64'sd1 <<< 41;
  localparam longint AMIN = -(64'sd1 <<< 24);
  localparam longint BMIN = -(64'sd1 <<< 34);

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic [24:0]        a;
  logic [34:0]        b;
  logic [47:0]        c;
  logic               acc;
  logic               ovf_clear;
  logic               out_valid, out_valid_r;
  logic signed [47:0] p, p_r;
  logic               ovf, ovf_r;

  always #5 clock = ~clock;

  mult_wide_mac dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .a(a), .b(b),
    .c(c), .acc(acc), .ovf_clear(ovf_clear), .out_valid(out_valid), .p(p),
    .ovf(ovf)
  );

  mult_wide_mac #(.ROUND(1)) dut_r (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .a(a), .b(b),
    .c(c), .acc(acc), .ovf_clear(ovf_clear), .out_valid(out_valid_r),
    .p(p_r), .ovf(ovf_r)
  );

  typedef struct {
    int     due;
    longint t;
    longint tr;
    bit     acc;
  } pend_t;

  pend_t       pend_q[$];
  logic [47:0] exp_q[$];
  int          cyc;
  int          checks;
  int          errors;
  bit          exp_v;
  longint      mp, mpr;
  bit          movf, movfr;

  function automatic longint ref_t(longint av, longint bv, longint cv, bit rnd);
    longint s;
    s = av * bv + cv;
    if (rnd) s = s + (64'sd1 <<< 16);
    return s >>> 17;
  endfunction

  function automatic longint sat_sum(longint pm, longint t, bit ac, output bit s);
    longint r;
    r = (ac ? pm : 64'sd0) + t;
    s = (r > PMAX) || (r < PMIN);
    if (r > PMAX) r = PMAX;
    else if (r < PMIN) r = PMIN;
    return r;
  endfunction

  function automatic longint pick(int w);
    longint v;
    int     sel;
    sel = $urandom_range(0, 7);
    v = {$urandom(), $urandom()};
    v = (v <<< (64 - w)) >>> (64 - w);
    if (sel == 0) v = (64'sd1 <<< (w - 1)) - 1;
    else if (sel == 1) v = -(64'sd1 <<< (w - 1));
    return v;
  endfunction

  // Driver + model: drive one cycle of inputs, advance the model across the
  // rising edge, and return at the following falling edge.
  task automatic step(input bit v, input longint av, input longint bv,
                      input longint cv, input bit iacc, input bit clr);
    pend_t e;
    bit    s;
    in_valid  = v;
    a         = av[24:0];
    b         = bv[34:0];
    c         = cv[47:0];
    acc       = iacc;
    ovf_clear = clr;
    @(posedge clock);
    cyc++;
    exp_v = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      e     = pend_q.pop_front();
      exp_v = 1'b1;
      mp    = sat_sum(mp, e.t, e.acc, s);
      movf  = s ? 1'b1 : (clr ? 1'b0 : movf);
      mpr   = sat_sum(mpr, e.tr, e.acc, s);
      movfr = s ? 1'b1 : (clr ? 1'b0 : movfr);
    end else if (clr) begin
      movf  = 1'b0;
      movfr = 1'b0;
    end
    if (v) pend_q.push_back('{due: cyc + LAT, t: ref_t(av, bv, cv, 1'b0),
                             tr: ref_t(av, bv, cv, 1'b1), acc: iacc});
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    pend_q.delete();
    mp = 0; mpr = 0; movf = 1'b0; movfr = 1'b0; exp_v = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (p !== 48'd0) begin errors++; $display("FAIL reset_p: got %0d want 0", p); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (p_r !== 48'd0 || out_valid_r !== 1'b0 || ovf_r !== 1'b0) begin errors++; $display("FAIL reset_round_inst: got p=%0d v=%b o=%b want 0", p_r, out_valid_r, ovf_r); end
    release_reset();
  endtask

  task automatic test_basic();
    int     first;
    longint pv;
    first = -1; pv = -99;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 3, 64'sd1 <<< 17, 0, 1'b0, 1'b0);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL basic_valid: step %0d got %b want %b", i, out_valid, exp_v); end
      checks++; if (p !== mp[47:0] || ovf !== movf) begin errors++; $display("FAIL basic_p: step %0d got %0d/%b want %0d/%b", i, p, ovf, mp, movf); end
      if (out_valid && first < 0) begin first = i; pv = longint'(p); end
    end
    checks++; if (first != LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", first, LAT); end
    checks++; if (pv != 3) begin errors++; $display("FAIL basic_value: got %0d want 3", pv); end
  endtask

  task automatic test_signs();
    longint av[2] = '{-1, -5};
    longint bv[2] = '{-1, BMIN};
    longint cv[2] = '{(64'sd1 <<< 17) - 1, 0};
    longint want[2] = '{1, 655360};
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i <= LAT; i++) begin
        step(i == 0, av[n], bv[n], cv[n], 1'b0, 1'b0);
        checks++; if (out_valid !== exp_v || p !== mp[47:0]) begin errors++; $display("FAIL signs_track: case %0d step %0d got %b/%0d want %b/%0d", n, i, out_valid, p, exp_v, mp); end
      end
      checks++; if (p !== want[n][47:0]) begin errors++; $display("FAIL signs_value: case %0d got %0d want %0d", n, p, want[n]); end
    end
  endtask

  task automatic test_rounding();
    longint av[2]   = '{1, -1};
    longint want[2] = '{0, -1};
    longint wantr[2] = '{1, 0};
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i <= LAT; i++) begin
        step(i == 0, av[n], 64'sd1 <<< 16, 0, 1'b0, 1'b0);
        checks++; if (out_valid_r !== exp_v || p_r !== mpr[47:0] || ovf_r !== movfr) begin errors++; $display("FAIL round_track: case %0d step %0d got %b/%0d want %b/%0d", n, i, out_valid_r, p_r, exp_v, mpr); end
      end
      checks++; if (p !== want[n][47:0]) begin errors++; $display("FAIL round_off_value: case %0d got %0d want %0d", n, p, want[n]); end
      checks++; if (p_r !== wantr[n][47:0]) begin errors++; $display("FAIL round_on_value: case %0d got %0d want %0d", n, p_r, wantr[n]); end
    end
  endtask

  task automatic test_accumulate();
    bit vpat[12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    bit first;
    first = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(48'(k));
    for (int i = 0; i < 12; i++) begin
      step(vpat[i], 1, 64'sd1 <<< 17, 0, !first, 1'b0);
      if (vpat[i]) first = 1'b0;
      checks++; if (out_valid !== exp_v || p !== mp[47:0]) begin errors++; $display("FAIL acc_track: step %0d got %b/%0d want %b/%0d", i, out_valid, p, exp_v, mp); end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL acc_extra_pulse: step %0d got p=%0d want no pulse", i, p); end
        else if (p !== exp_q[0]) begin errors++; $display("FAIL acc_pulse: step %0d got %0d want %0d", i, p, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL acc_missing: got %0d pulses short want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_saturation();
    int     n;
    longint p63;
    apply_reset();
    release_reset();
    n = 0; p63 = 0;
    for (int i = 0; i < 64 + LAT + 1; i++) begin
      step(i < 64, AMIN, BMIN, 0, 1'b1, 1'b0);
      checks++; if (out_valid !== exp_v || p !== mp[47:0] || ovf !== movf) begin errors++; $display("FAIL sat_track: step %0d got %b/%0d/%b want %b/%0d/%b", i, out_valid, p, ovf, exp_v, mp, movf); end
      if (out_valid) begin n++; if (n == 63) p63 = longint'(p); end
    end
    checks++; if (p63 != PMAX + 1 - T41) begin errors++; $display("FAIL sat_63: got %0d want %0d", p63, PMAX + 1 - T41); end
    checks++; if (p !== PMAX[47:0] || ovf !== 1'b1) begin errors++; $display("FAIL sat_pin: got %0d/%b want %0d/1", p, ovf, PMAX); end
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b want 0", ovf); end
    for (int i = 0; i <= LAT; i++) begin
      step(i == 0, AMIN, BMIN, 0, 1'b1, 1'b1);
      checks++; if (out_valid !== exp_v || ovf !== movf) begin errors++; $display("FAIL sat_setwins_track: step %0d got %b/%b want %b/%b", i, out_valid, ovf, exp_v, movf); end
      if (out_valid) begin
        checks++; if (ovf !== 1'b1 || p !== PMAX[47:0]) begin errors++; $display("FAIL sat_setwins: got %0d/%b want %0d/1", p, ovf, PMAX); end
      end
    end
    for (int i = 0; i <= LAT; i++) begin
      step(i == 0, AMIN, BMIN, 0, 1'b0, 1'b0);
      checks++; if (out_valid !== exp_v || p !== mp[47:0] || ovf !== movf) begin errors++; $display("FAIL sat_restart_track: step %0d got %b/%0d/%b want %b/%0d/%b", i, out_valid, p, ovf, exp_v, mp, movf); end
    end
    checks++; if (p !== T41[47:0] || ovf !== 1'b1) begin errors++; $display("FAIL sat_restart: got %0d/%b want %0d/1", p, ovf, T41); end
  endtask

  task automatic test_reset_midflight();
    int first;
    for (int i = 0; i < 3; i++) step(1'b1, 7, 64'sd1 <<< 17, 0, 1'b1, 1'b0);
    apply_reset();
    checks++; if (out_valid !== 1'b0 || p !== 48'd0 || ovf !== 1'b0) begin errors++; $display("FAIL midflight_reset: got %b/%0d/%b want 0/0/0", out_valid, p, ovf); end
    release_reset();
    first = -1;
    for (int i = 0; i < 2 * LAT + 3; i++) begin
      step(i == LAT + 2, 2, 64'sd1 <<< 17, 0, 1'b1, 1'b0);
      checks++; if (out_valid !== exp_v || p !== mp[47:0] || ovf !== movf) begin errors++; $display("FAIL midflight_track: step %0d got %b/%0d/%b want %b/%0d/%b", i, out_valid, p, ovf, exp_v, mp, movf); end
      if (out_valid && first < 0) first = i;
    end
    checks++; if (first != 2 * LAT + 2) begin errors++; $display("FAIL midflight_first: got %0d want %0d", first, 2 * LAT + 2); end
    checks++; if (p !== 48'd2) begin errors++; $display("FAIL midflight_value: got %0d want 2", p); end
  endtask

  task automatic test_random();
    bit v, ac, cl;
    for (int i = 0; i < 10000 + LAT + 1; i++) begin
      v  = (i < 10000) && ($urandom_range(0, 4) != 0);
      ac = ($urandom_range(0, 1) == 1);
      cl = ($urandom_range(0, 19) == 0);
      step(v, pick(25), pick(35), pick(48), ac, cl);
      checks++; if (out_valid !== exp_v || out_valid_r !== exp_v) begin errors++; $display("FAIL rand_valid: step %0d got %b/%b want %b", i, out_valid, out_valid_r, exp_v); end
      checks++; if (p !== mp[47:0] || ovf !== movf) begin errors++; $display("FAIL rand_p: step %0d got %0d/%b want %0d/%b", i, p, ovf, mp, movf); end
      checks++; if (p_r !== mpr[47:0] || ovf_r !== movfr) begin errors++; $display("FAIL rand_p_round: step %0d got %0d/%b want %0d/%b", i, p_r, ovf_r, mpr, movfr); end
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    acc = 1'b0; ovf_clear = 1'b0;
    cyc = 0; checks = 0; errors = 0; exp_v = 1'b0;
    mp = 0; mpr = 0; movf = 1'b0; movfr = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_basic();
    test_signs();
    test_rounding();
    test_accumulate();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
